// File: rtl/bitonic_sort_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bitonic_sort_pipe_if
// Brief    : Input/output vector handshake bundle for bitonic_sort_pipe.
// Revision : 1.0
// ============================================================================
interface bitonic_sort_pipe_if #(
    parameter int LOG_N  = 3,
    parameter int DATA_W = 7,
    parameter int TAG_W  = 3
);
    localparam int c_n = 1 << LOG_N;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_desc;
    logic [c_n*DATA_W-1:0] in_key;
    logic [c_n*TAG_W-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_desc;
    logic [c_n*DATA_W-1:0] out_key;
    logic [c_n*TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_desc, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_desc, out_key, out_tag
    );

    modport slave (
        input  in_valid, in_desc, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_desc, out_key, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/bitonic_sort_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitonic_sort_pipe
// Brief    : Pipelined bitonic sorter of 2^LOG_N {key,tag} pairs, one merge
//            phase per stage, valid/ready with bubble collapsing.
// Revision : 1.0
// ============================================================================
module bitonic_sort_pipe #(
    parameter int LOG_N  = 3,
    parameter int DATA_W = 7,
    parameter int TAG_W  = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bitonic_sort_pipe_if.slave bus
);
    localparam int c_n  = 1 << LOG_N;
    localparam int c_ew = DATA_W + TAG_W;
    localparam int c_vw = c_n * c_ew;

    // Index 0 is the input vector; index k is the stage-k register.
    logic [c_vw-1:0]  w_data [LOG_N+1];
    logic [LOG_N:0]   w_v;
    logic [LOG_N:0]   w_desc;
    logic [LOG_N-1:0] w_adv;

    assign w_v[0]        = bus.in_valid;
    assign w_desc[0]     = bus.in_desc;
    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = w_v[LOG_N];
    assign bus.out_desc  = w_desc[LOG_N];

    for (genvar gi = 0; gi < c_n; gi++) begin : g_elem
        // Tag sits in the low bits so an unsigned compare orders {key, tag}.
        assign w_data[0][gi*c_ew +: c_ew] =
            {bus.in_key[gi*DATA_W +: DATA_W], bus.in_tag[gi*TAG_W +: TAG_W]};
        assign bus.out_key[gi*DATA_W +: DATA_W] = w_data[LOG_N][gi*c_ew+TAG_W +: DATA_W];
        assign bus.out_tag[gi*TAG_W +: TAG_W]   = w_data[LOG_N][gi*c_ew +: TAG_W];
    end

    always_comb begin
        w_adv[LOG_N-1] = !w_v[LOG_N] || bus.out_ready;
        for (int k = LOG_N - 2; k >= 0; k--) begin
            w_adv[k] = !w_v[k+1] || w_adv[k+1];
        end
    end

    for (genvar gs = 0; gs < LOG_N; gs++) begin : g_stage
        logic [c_vw-1:0] w_net;
        logic [c_vw-1:0] r_data;
        logic            r_v;
        logic            r_desc;

        // Merge phase gs+1: layers of distance 2^gs down to 1.
        always_comb begin
            logic [c_ew-1:0] a;
            logic [c_ew-1:0] b;
            logic            up;
            w_net = w_data[gs];
            a     = '0;
            b     = '0;
            up    = 1'b1;
            for (int j = gs; j >= 0; j--) begin
                for (int i = 0; i < c_n; i++) begin
                    if ((i & (1 << j)) == 0) begin
                        a  = w_net[i*c_ew +: c_ew];
                        b  = w_net[(i + (1 << j))*c_ew +: c_ew];
                        // Inner phases alternate direction per run to form bitonic runs.
                        up = (gs == LOG_N - 1) ? !w_desc[gs]
                                               : (((i >> (gs + 1)) & 1) == 0);
                        if (up ? (a > b) : (a < b)) begin
                            w_net[i*c_ew +: c_ew]              = b;
                            w_net[(i + (1 << j))*c_ew +: c_ew] = a;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v    <= 1'b0;
                r_desc <= 1'b0;
                r_data <= '0;
            end else if (w_adv[gs]) begin
                r_v <= w_v[gs];
                if (w_v[gs]) begin
                    r_data <= w_net;
                    r_desc <= w_desc[gs];
                end
            end
        end

        assign w_data[gs+1] = r_data;
        assign w_v[gs+1]    = r_v;
        assign w_desc[gs+1] = r_desc;
    end
endmodule
`default_nettype wire

// File: tb/tb_bitonic_sort_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitonic_sort_pipe
// Brief    : Self-checking bench for bitonic_sort_pipe at LOG_N = 3, 2 and 5.
// Revision : 1.0
// ============================================================================
module tb_bitonic_sort_pipe;
    localparam int W  = 256;
    localparam int K3 = 8 * 7;
    localparam int T3 = 8 * 3;
    localparam int K2 = 4 * 4;
    localparam int T2 = 4 * 2;
    localparam int K5 = 32 * 8;
    localparam int T5 = 32 * 5;

    typedef logic [W-1:0] vec_t;
    typedef struct {
        vec_t k;
        vec_t t;
        logic d;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bitonic_sort_pipe_if #(.LOG_N(3), .DATA_W(7), .TAG_W(3)) b3 ();
    bitonic_sort_pipe_if #(.LOG_N(2), .DATA_W(4), .TAG_W(2)) b2 ();
    bitonic_sort_pipe_if #(.LOG_N(5), .DATA_W(8), .TAG_W(5)) b5 ();

    bitonic_sort_pipe #(.LOG_N(3), .DATA_W(7), .TAG_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    bitonic_sort_pipe #(.LOG_N(2), .DATA_W(4), .TAG_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    bitonic_sort_pipe #(.LOG_N(5), .DATA_W(8), .TAG_W(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    int seq8 [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int rev8 [8] = '{7, 6, 5, 4, 3, 2, 1, 0};
    int bk   [8] = '{5, 3, 7, 1, 6, 2, 4, 0};
    int btag [8] = '{7, 3, 5, 1, 6, 0, 4, 2};
    int nine [8] = '{9, 9, 9, 9, 9, 9, 9, 9};
    int k2i  [8] = '{15, 0, 15, 0, 0, 0, 0, 0};
    int k2o  [8] = '{0, 0, 15, 15, 0, 0, 0, 0};
    int t2o  [8] = '{1, 3, 0, 2, 0, 0, 0, 0};

    exp_t sb [3][$];

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sort the combined {key,tag} integers, then split back out.
    function automatic exp_t model(input int n, input int dw, input int tw, input logic d,
                                   input vec_t key, input vec_t tag);
        longint q[$];
        exp_t   e;
        vec_t   km = (vec_t'(1) << dw) - vec_t'(1);
        vec_t   tm = (vec_t'(1) << tw) - vec_t'(1);
        for (int i = 0; i < n; i++) begin
            q.push_back((longint'((key >> (i * dw)) & km) << tw) | longint'((tag >> (i * tw)) & tm));
        end
        if (d) q.rsort();
        else   q.sort();
        e.k = '0;
        e.t = '0;
        e.d = d;
        for (int i = 0; i < n; i++) begin
            e.k |= vec_t'(q[i] >> tw) << (i * dw);
            e.t |= (vec_t'(q[i]) & tm) << (i * tw);
        end
        return e;
    endfunction

    function automatic vec_t pack(input int n, input int w, input int a[8]);
        vec_t v = '0;
        for (int i = 0; i < n; i++) v |= vec_t'(a[i]) << (i * w);
        return v;
    endfunction

    function automatic vec_t rnd();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic monitor(input int id, input int n, input int dw, input int tw,
                           input logic iv, input logic ir, input logic idesc,
                           input vec_t ik, input vec_t it,
                           input logic ov, input logic ordy, input logic od,
                           input vec_t ok, input vec_t ot);
        if (!rst_n) begin
            sb[id].delete();
            return;
        end
        if (ov) begin
            if (sb[id].size() == 0) begin
                check($sformatf("i%0d_extra_out_valid", id), vec_t'(ov), vec_t'(0));
            end else begin
                check($sformatf("i%0d_out_key", id), ok, sb[id][0].k);
                check($sformatf("i%0d_out_tag", id), ot, sb[id][0].t);
                check($sformatf("i%0d_out_desc", id), vec_t'(od), vec_t'(sb[id][0].d));
                if (ordy) void'(sb[id].pop_front());
            end
        end
        if (iv && ir) sb[id].push_back(model(n, dw, tw, idesc, ik, it));
    endtask

    always @(negedge clk) begin
        monitor(0, 8, 7, 3, b3.in_valid, b3.in_ready, b3.in_desc, vec_t'(b3.in_key), vec_t'(b3.in_tag),
                b3.out_valid, b3.out_ready, b3.out_desc, vec_t'(b3.out_key), vec_t'(b3.out_tag));
        monitor(1, 4, 4, 2, b2.in_valid, b2.in_ready, b2.in_desc, vec_t'(b2.in_key), vec_t'(b2.in_tag),
                b2.out_valid, b2.out_ready, b2.out_desc, vec_t'(b2.out_key), vec_t'(b2.out_tag));
        monitor(2, 32, 8, 5, b5.in_valid, b5.in_ready, b5.in_desc, vec_t'(b5.in_key), vec_t'(b5.in_tag),
                b5.out_valid, b5.out_ready, b5.out_desc, vec_t'(b5.out_key), vec_t'(b5.out_tag));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic v, input logic d, input vec_t k, input vec_t t);
        b3.in_valid = v;
        b3.in_desc  = d;
        b3.in_key   = k[K3-1:0];
        b3.in_tag   = t[T3-1:0];
        #1;
    endtask

    vec_t va, vb, vc, vd, ta, tb, tc, td;
    exp_t ea, eb;

    initial begin
        b3.in_valid = 1'b0; b3.in_desc = 1'b0; b3.in_key = '0; b3.in_tag = '0; b3.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.in_desc = 1'b0; b2.in_key = '0; b2.in_tag = '0; b2.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.in_desc = 1'b0; b5.in_key = '0; b5.in_tag = '0; b5.out_ready = 1'b1;
        repeat (2) step();

        check("rst_out_valid", vec_t'(b3.out_valid), vec_t'(0));
        check("rst_out_key", vec_t'(b3.out_key), vec_t'(0));
        check("rst_out_tag", vec_t'(b3.out_tag), vec_t'(0));
        check("rst_out_desc", vec_t'(b3.out_desc), vec_t'(0));
        check("rst5_out_valid", vec_t'(b5.out_valid), vec_t'(0));
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", vec_t'(b3.in_ready), vec_t'(1));

        // Basic ascending sort with exact latency
        drive3(1'b1, 1'b0, pack(8, 7, bk), pack(8, 3, seq8));
        step();
        drive3(1'b0, 1'b0, '0, '0);
        check("basic_lat1", vec_t'(b3.out_valid), vec_t'(0));
        step();
        check("basic_lat2", vec_t'(b3.out_valid), vec_t'(0));
        step();
        check("basic_valid", vec_t'(b3.out_valid), vec_t'(1));
        check("basic_key", vec_t'(b3.out_key), pack(8, 7, seq8));
        check("basic_tag", vec_t'(b3.out_tag), pack(8, 3, btag));

        // Ties resolved by tag, ascending then descending back-to-back
        drive3(1'b1, 1'b0, pack(8, 7, nine), pack(8, 3, seq8));
        step();
        drive3(1'b1, 1'b1, pack(8, 7, nine), pack(8, 3, seq8));
        step();
        drive3(1'b0, 1'b0, '0, '0);
        step();
        check("tie_asc_tag", vec_t'(b3.out_tag), pack(8, 3, seq8));
        check("tie_asc_desc", vec_t'(b3.out_desc), vec_t'(0));
        step();
        check("tie_desc_tag", vec_t'(b3.out_tag), pack(8, 3, rev8));
        check("tie_desc_desc", vec_t'(b3.out_desc), vec_t'(1));
        check("tie_desc_key", vec_t'(b3.out_key), pack(8, 7, nine));
        repeat (3) step();

        // Backpressure: three accepted, fourth waits, A held stable
        va = rnd(); vb = rnd(); vc = rnd(); vd = rnd();
        ta = rnd(); tb = rnd(); tc = rnd(); td = rnd();
        ea = model(8, 7, 3, 1'b0, va & ((vec_t'(1) << K3) - 1), ta & ((vec_t'(1) << T3) - 1));
        b3.out_ready = 1'b0;
        drive3(1'b1, 1'b0, va, ta);
        step();
        drive3(1'b1, 1'b0, vb, tb);
        step();
        drive3(1'b1, 1'b0, vc, tc);
        check("bp_c_in_ready", vec_t'(b3.in_ready), vec_t'(1));
        step();
        drive3(1'b1, 1'b0, vd, td);
        check("bp_full_in_ready", vec_t'(b3.in_ready), vec_t'(0));
        step();
        check("bp_hold_in_ready", vec_t'(b3.in_ready), vec_t'(0));
        check("bp_hold_key_a", vec_t'(b3.out_key), ea.k);
        step();
        check("bp_hold_key_a2", vec_t'(b3.out_key), ea.k);
        check("bp_hold_tag_a2", vec_t'(b3.out_tag), ea.t);
        b3.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", vec_t'(b3.in_ready), vec_t'(1));
        step();
        drive3(1'b0, 1'b0, '0, '0);
        repeat (3) step();
        check("bp_drained", vec_t'(b3.out_valid), vec_t'(0));

        // Bubble collapse while the output stalls
        va = rnd(); vb = rnd(); vc = rnd();
        ea = model(8, 7, 3, 1'b1, va & ((vec_t'(1) << K3) - 1), ta & ((vec_t'(1) << T3) - 1));
        b3.out_ready = 1'b0;
        drive3(1'b1, 1'b1, va, ta);
        step();
        drive3(1'b0, 1'b0, '0, '0);
        repeat (2) step();
        drive3(1'b1, 1'b0, vb, tb);
        check("bub_b_in_ready", vec_t'(b3.in_ready), vec_t'(1));
        step();
        drive3(1'b1, 1'b1, vc, tc);
        check("bub_c_in_ready", vec_t'(b3.in_ready), vec_t'(1));
        step();
        drive3(1'b0, 1'b0, '0, '0);
        check("bub_full_in_ready", vec_t'(b3.in_ready), vec_t'(0));
        check("bub_out_a", vec_t'(b3.out_key), ea.k);
        b3.out_ready = 1'b1;
        repeat (4) step();

        // LOG_N = 2 directed with 2-edge latency
        b2.in_valid = 1'b1;
        b2.in_key   = K2'(pack(4, 4, k2i));
        b2.in_tag   = T2'(pack(4, 2, seq8));
        step();
        b2.in_valid = 1'b0;
        check("p2_lat1", vec_t'(b2.out_valid), vec_t'(0));
        step();
        check("p2_valid", vec_t'(b2.out_valid), vec_t'(1));
        check("p2_key", vec_t'(b2.out_key), pack(4, 4, k2o));
        check("p2_tag", vec_t'(b2.out_tag), pack(4, 2, t2o));
        step();

        // Mid-flight reset with three vectors in the pipe
        for (int i = 0; i < 3; i++) begin
            drive3(1'b1, i[0], rnd(), rnd());
            step();
        end
        drive3(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", vec_t'(b3.out_valid), vec_t'(0));
        check("mrst_out_key", vec_t'(b3.out_key), vec_t'(0));
        check("mrst_out_tag", vec_t'(b3.out_tag), vec_t'(0));
        step();
        rst_n = 1'b1;
        #1;
        check("mrst_in_ready", vec_t'(b3.in_ready), vec_t'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_no_stale", vec_t'(b3.out_valid), vec_t'(0));
        end

        // Random regression on all three sizes
        for (int c = 0; c < 600; c++) begin
            vb = rnd();
            if ($urandom_range(0, 7) == 0) vb = '0;
            if ($urandom_range(0, 7) == 0) vb = '1;
            tb = rnd();
            b3.in_valid = ($urandom_range(0, 3) != 0); b3.in_desc = $urandom_range(0, 1) == 1;
            b3.in_key = vb[K3-1:0]; b3.in_tag = tb[T3-1:0]; b3.out_ready = ($urandom_range(0, 3) != 0);
            b2.in_valid = ($urandom_range(0, 3) != 0); b2.in_desc = $urandom_range(0, 1) == 1;
            b2.in_key = vb[K2-1:0]; b2.in_tag = tb[T2-1:0]; b2.out_ready = ($urandom_range(0, 3) != 0);
            b5.in_valid = ($urandom_range(0, 3) != 0); b5.in_desc = $urandom_range(0, 1) == 1;
            b5.in_key = vb[K5-1:0]; b5.in_tag = tb[T5-1:0]; b5.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        b3.in_valid = 1'b0; b3.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.out_ready = 1'b1;
        repeat (10) step();
        check("drain_q3", vec_t'(sb[0].size()), vec_t'(0));
        check("drain_q2", vec_t'(sb[1].size()), vec_t'(0));
        check("drain_q5", vec_t'(sb[2].size()), vec_t'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
